// File: rtl/cache_pkg.sv
// cache_pkg: types and defaults shared by the cache and its port arbiter.
// Holds the default word size, the port index type and the arbiter FSM states.
package cache_pkg;

  localparam int DEFAULT_WORD_SIZE = 256;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Round-robin successor over the three ports: 0 -> 1 -> 2 -> 0.
  function automatic port_idx_t next_idx(port_idx_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: one classic Wishbone link (cyc/stb/we/addr/mosi, ack/miso).
// master = side that starts cycles, slave = side that acks them.
interface cache_port_arbiter_if
  import cache_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) ();

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [31:0]          addr;
  logic [WORD_SIZE-1:0] mosi;
  logic                 ack;
  logic [WORD_SIZE-1:0] miso;

  modport master (
    output cyc, stb, we, addr, mosi,
    input  ack, miso
  );

  modport slave (
    input  cyc, stb, we, addr, mosi,
    output ack, miso
  );

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search over 3 request lines.
// Ports: i_req (request vector), i_ptr (search start), o_winner, o_valid.
module rr_priority_picker
  import cache_pkg::*;
(
  input  logic [2:0] i_req,
  input  port_idx_t  i_ptr,
  output port_idx_t  o_winner,
  output logic       o_valid
);

  always_comb begin : pick
    port_idx_t idx;
    o_winner = i_ptr;
    o_valid  = 1'b0;
    idx      = i_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!o_valid && i_req[idx]) begin
        o_winner = idx;
        o_valid  = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the cache slave port between three Wishbone masters.
// Ports: clk, rst_n, wishbone_0..2 (requesters), cache (to cache), grant_o (one-hot owner).
module cache_port_arbiter
  import cache_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cache_port_arbiter_if.slave         wishbone_0,
  cache_port_arbiter_if.slave         wishbone_1,
  cache_port_arbiter_if.slave         wishbone_2,
  cache_port_arbiter_if.master        cache,
  output logic [2:0]                  grant_o
);

  arb_state_t r_state;
  port_idx_t  r_rr_ptr;
  port_idx_t  r_gidx;
  logic [2:0] r_grant;

  logic [2:0] w_cyc;
  logic [2:0] w_stb;
  logic [2:0] w_req;
  port_idx_t  w_win;
  logic       w_valid;
  logic [2:0] w_onehot;
  logic       w_busy;
  logic       w_ack_g;

  logic                 w_cyc_g;
  logic                 w_stb_g;
  logic                 w_we_g;
  logic [31:0]          w_addr_g;
  logic [WORD_SIZE-1:0] w_mosi_g;

  assign w_cyc = {wishbone_2.cyc, wishbone_1.cyc, wishbone_0.cyc};
  assign w_stb = {wishbone_2.stb, wishbone_1.stb, wishbone_0.stb};
  assign w_req = w_cyc & w_stb;

  rr_priority_picker u_pick (
    .i_req    (w_req),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_win),
    .o_valid  (w_valid)
  );

  assign w_onehot = 3'b001 << w_win;
  assign w_busy   = (r_state == BUSY);

  always_comb begin
    w_cyc_g  = wishbone_0.cyc;
    w_stb_g  = wishbone_0.stb;
    w_we_g   = wishbone_0.we;
    w_addr_g = wishbone_0.addr;
    w_mosi_g = wishbone_0.mosi;
    case (r_gidx)
      2'd1: begin
        w_cyc_g  = wishbone_1.cyc;
        w_stb_g  = wishbone_1.stb;
        w_we_g   = wishbone_1.we;
        w_addr_g = wishbone_1.addr;
        w_mosi_g = wishbone_1.mosi;
      end
      2'd2: begin
        w_cyc_g  = wishbone_2.cyc;
        w_stb_g  = wishbone_2.stb;
        w_we_g   = wishbone_2.we;
        w_addr_g = wishbone_2.addr;
        w_mosi_g = wishbone_2.mosi;
      end
      default: ;
    endcase
  end

  assign cache.cyc  = w_busy & w_cyc_g;
  assign cache.stb  = w_busy & w_stb_g;
  assign cache.we   = w_busy & w_we_g;
  assign cache.addr = w_busy ? w_addr_g : '0;
  assign cache.mosi = w_busy ? w_mosi_g : '0;

  // An owner that has dropped cyc has aborted; a late ack is not routed.
  assign w_ack_g = w_busy & w_cyc_g & cache.ack;

  // r_grant is only non-zero in BUSY, so it doubles as the route enable.
  assign wishbone_0.ack  = w_ack_g & r_grant[0];
  assign wishbone_1.ack  = w_ack_g & r_grant[1];
  assign wishbone_2.ack  = w_ack_g & r_grant[2];
  assign wishbone_0.miso = r_grant[0] ? cache.miso : '0;
  assign wishbone_1.miso = r_grant[1] ? cache.miso : '0;
  assign wishbone_2.miso = r_grant[2] ? cache.miso : '0;

  assign grant_o = r_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= 2'd0;
      r_gidx   <= 2'd0;
      r_grant  <= 3'b000;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= BUSY;
            r_gidx  <= w_win;
            r_grant <= w_onehot;
          end
        end
        BUSY: begin
          if (!w_cyc_g) begin
            r_state <= IDLE;
            r_grant <= 3'b000;
          end else if (cache.ack) begin
            r_state  <= IDLE;
            r_grant  <= 3'b000;
            r_rr_ptr <= next_idx(r_gidx);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: vector table plus hand-written sequences with a
// grant-order scoreboard for the three-port cache arbiter.
module tb_cache_port_arbiter;
  import cache_pkg::*;

  localparam int W = DEFAULT_WORD_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.WORD_SIZE(W)) wb0 ();
  cache_port_arbiter_if #(.WORD_SIZE(W)) wb1 ();
  cache_port_arbiter_if #(.WORD_SIZE(W)) wb2 ();
  cache_port_arbiter_if #(.WORD_SIZE(W)) cif ();

  logic [2:0]   t_cyc = '0;
  logic [2:0]   t_stb = '0;
  logic [2:0]   t_we  = '0;
  logic [31:0]  t_addr [3];
  logic [W-1:0] t_mosi [3];
  logic [2:0]   t_ack;
  logic [W-1:0] t_miso [3];
  logic [2:0]   grant;
  logic         c_ack = 1'b0;
  logic [W-1:0] c_miso = '0;

  assign wb0.cyc = t_cyc[0];
  assign wb0.stb = t_stb[0];
  assign wb0.we = t_we[0];
  assign wb0.addr = t_addr[0];
  assign wb0.mosi = t_mosi[0];
  assign wb1.cyc = t_cyc[1];
  assign wb1.stb = t_stb[1];
  assign wb1.we = t_we[1];
  assign wb1.addr = t_addr[1];
  assign wb1.mosi = t_mosi[1];
  assign wb2.cyc = t_cyc[2];
  assign wb2.stb = t_stb[2];
  assign wb2.we = t_we[2];
  assign wb2.addr = t_addr[2];
  assign wb2.mosi = t_mosi[2];
  assign t_ack = {wb2.ack, wb1.ack, wb0.ack};
  assign t_miso[0] = wb0.miso;
  assign t_miso[1] = wb1.miso;
  assign t_miso[2] = wb2.miso;
  assign cif.ack = c_ack;
  assign cif.miso = c_miso;

  cache_port_arbiter #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wishbone_0 (wb0),
    .wishbone_1 (wb1),
    .wishbone_2 (wb2),
    .cache      (cif),
    .grant_o    (grant)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  mask;
    int          exp;
    logic        we;
    logic [31:0] addr;
    int          lat;
  } vec_t;
  vec_t vt[8];

  function automatic logic [W-1:0] mosi_of(logic [31:0] a);
    return {(W/32){a ^ 32'hDEAD_0000}};
  endfunction

  function automatic logic [W-1:0] miso_of(logic [31:0] a);
    return {(W/32){a ^ 32'hA5A5_0000}};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(int p, logic [31:0] a, logic we, logic on);
    t_cyc[p]  = on;
    t_stb[p]  = on;
    t_we[p]   = on & we;
    t_addr[p] = a;
    t_mosi[p] = mosi_of(a);
  endtask

  task automatic drop_all();
    for (int p = 0; p < 3; p++) drive_req(p, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic check_idle(string tag);
    check({tag, " grant"}, W'(grant), W'(3'b000));
    check({tag, " cyc"}, W'(cif.cyc), W'(1'b0));
    check({tag, " stb"}, W'(cif.stb), W'(1'b0));
    check({tag, " we"}, W'(cif.we), W'(1'b0));
    check({tag, " addr"}, W'(cif.addr), W'(32'h0));
    check({tag, " mosi"}, cif.mosi, '0);
    check({tag, " acks"}, W'(t_ack), W'(3'b000));
    for (int i = 0; i < 3; i++)
      check($sformatf("%s miso%0d", tag, i), t_miso[i], '0);
  endtask

  task automatic do_reset();
    drop_all();
    c_ack  = 1'b0;
    c_miso = '0;
    rst_n  = 1'b0;
    #2;
    check_idle("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Wait for cache_stb, then pop the scoreboard and compare the forwarded bus.
  task automatic wait_grant(string tag, output int port);
    bit seen = 1'b0;
    int n = 0;
    exp_t e;
    port = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cif.stb === 1'b1) begin
        seen = 1'b1;
        n = k;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no cache_stb within 12 cycles", tag);
      return;
    end
    check({tag, " latency"}, W'(n), W'(1));
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: grant seen, got empty queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    port = e.port;
    check({tag, " grant"}, W'(grant), W'(3'b001 << e.port));
    check({tag, " cyc"}, W'(cif.cyc), W'(1'b1));
    check({tag, " addr"}, W'(cif.addr), W'(e.addr));
    check({tag, " we"}, W'(cif.we), W'(e.we));
    check({tag, " mosi"}, cif.mosi, mosi_of(e.addr));
  endtask

  // Called at a negedge with stb high; acks after lat further cycles.
  task automatic do_ack(string tag, int p, int lat);
    logic [31:0] a;
    logic w;
    a = t_addr[p];
    w = t_we[p];
    for (int k = 0; k < lat; k++) begin
      check({tag, " early ack"}, W'(t_ack), W'(3'b000));
      @(negedge clk);
      check({tag, " stb hold"}, W'(cif.stb), W'(1'b1));
      check({tag, " addr hold"}, W'(cif.addr), W'(a));
      check({tag, " we hold"}, W'(cif.we), W'(w));
      check({tag, " mosi hold"}, cif.mosi, mosi_of(a));
    end
    c_ack  = 1'b1;
    c_miso = miso_of(a);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s ack%0d", tag, i), W'(t_ack[i]), W'(i == p));
      check($sformatf("%s miso%0d", tag, i), t_miso[i],
            (i == p) ? miso_of(a) : '0);
    end
    @(posedge clk);
    #1;
    c_ack  = 1'b0;
    c_miso = '0;
  endtask

  int got;

  initial begin
    for (int p = 0; p < 3; p++) begin
      t_addr[p] = 32'h0;
      t_mosi[p] = '0;
    end
    // mask, expected winner, we, addr, ack latency (rr starts at 0)
    vt[0] = '{3'b010, 1, 1'b0, 32'h0000_0040, 3};
    vt[1] = '{3'b111, 2, 1'b0, 32'h0000_0200, 0};
    vt[2] = '{3'b111, 0, 1'b1, 32'h0000_1000, 2};
    vt[3] = '{3'b101, 2, 1'b1, 32'h0000_0300, 1};
    vt[4] = '{3'b110, 1, 1'b0, 32'h0000_0404, 0};
    vt[5] = '{3'b011, 0, 1'b0, 32'h0000_0508, 1};
    vt[6] = '{3'b001, 0, 1'b1, 32'h0000_060C, 0};
    vt[7] = '{3'b100, 2, 1'b0, 32'h0000_0700, 0};

    #3;
    check_idle("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(posedge clk);
      #1;
      for (int p = 0; p < 3; p++) begin
        if (vt[i].mask[p]) begin
          if (p == vt[i].exp)
            drive_req(p, vt[i].addr, vt[i].we, 1'b1);
          else
            drive_req(p, 32'h2000_0000 + 32'(p * 16), ~vt[i].we, 1'b1);
        end
      end
      sb.push_back('{vt[i].exp, vt[i].addr, vt[i].we});
      wait_grant(tag, got);
      do_ack(tag, got, vt[i].lat);
      drop_all();
      @(negedge clk);
      check_idle({tag, " after"});
    end

    // Contention: everyone requests continuously from reset.
    do_reset();
    for (int p = 0; p < 3; p++) drive_req(p, 32'h3000_0000 + 32'(p), 1'b0, 1'b1);
    sb.push_back('{0, 32'h3000_0000, 1'b0});
    sb.push_back('{1, 32'h3000_0001, 1'b0});
    sb.push_back('{2, 32'h3000_0002, 1'b0});
    sb.push_back('{0, 32'h3000_0000, 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("cont%0d", k), got);
      do_ack($sformatf("cont%0d", k), got, 0);
    end
    drop_all();
    @(negedge clk);
    check_idle("cont end");

    // Fairness: port 0 always requesting, port 2 arrives once.
    do_reset();
    drive_req(0, 32'h4000_0000, 1'b0, 1'b1);
    sb.push_back('{0, 32'h4000_0000, 1'b0});
    wait_grant("fair0", got);
    drive_req(2, 32'h4000_0002, 1'b1, 1'b1);
    sb.push_back('{2, 32'h4000_0002, 1'b1});
    sb.push_back('{0, 32'h4000_0000, 1'b0});
    do_ack("fair0", got, 1);
    wait_grant("fair1", got);
    do_ack("fair1", got, 0);
    drive_req(2, 32'h0, 1'b0, 1'b0);
    wait_grant("fair2", got);
    do_ack("fair2", got, 0);
    drop_all();

    // Abort: port 2 drops cyc while owning the bus; rr_ptr must stay at 1.
    do_reset();
    drive_req(0, 32'h5000_0000, 1'b0, 1'b1);
    sb.push_back('{0, 32'h5000_0000, 1'b0});
    wait_grant("ab0", got);
    do_ack("ab0", got, 0);
    drop_all();
    @(posedge clk);
    #1 drive_req(2, 32'h5000_0002, 1'b0, 1'b1);
    sb.push_back('{2, 32'h5000_0002, 1'b0});
    wait_grant("ab1", got);
    @(posedge clk);
    #1;
    drive_req(2, 32'h5000_0002, 1'b0, 1'b0);
    c_ack  = 1'b1;
    c_miso = miso_of(32'h5000_0002);
    @(negedge clk);
    check("abort ack", W'(t_ack), W'(3'b000));
    check("abort cyc", W'(cif.cyc), W'(1'b0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort late ack", W'(t_ack), W'(3'b000));
    check("abort idle grant", W'(grant), W'(3'b000));
    check("abort idle stb", W'(cif.stb), W'(1'b0));
    @(posedge clk);
    #1;
    c_ack  = 1'b0;
    c_miso = '0;
    drive_req(0, 32'h5100_0000, 1'b0, 1'b1);
    drive_req(2, 32'h5100_0002, 1'b0, 1'b1);
    sb.push_back('{2, 32'h5100_0002, 1'b0});
    wait_grant("ab2", got);
    do_ack("ab2", got, 0);
    drop_all();

    // Async reset in BUSY; rr_ptr must return to 0 afterwards.
    do_reset();
    drive_req(0, 32'h6000_0000, 1'b0, 1'b1);
    sb.push_back('{0, 32'h6000_0000, 1'b0});
    wait_grant("rs0", got);
    do_ack("rs0", got, 0);
    drop_all();
    @(posedge clk);
    #1 drive_req(1, 32'h6000_0001, 1'b1, 1'b1);
    sb.push_back('{1, 32'h6000_0001, 1'b1});
    wait_grant("rs1", got);
    #1;
    rst_n = 1'b0;
    c_ack = 1'b1;
    c_miso = miso_of(32'h6000_0001);
    #1;
    check_idle("mid reset");
    @(posedge clk);
    #1;
    c_ack  = 1'b0;
    c_miso = '0;
    drive_req(1, 32'h0, 1'b0, 1'b0);
    drive_req(0, 32'h6100_0000, 1'b0, 1'b1);
    drive_req(2, 32'h6100_0002, 1'b0, 1'b1);
    rst_n = 1'b1;
    sb.push_back('{0, 32'h6100_0000, 1'b0});
    wait_grant("rs2", got);
    do_ack("rs2", got, 0);
    drop_all();
    @(negedge clk);
    check_idle("rs end");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
